// File: rtl/r0_writeback_collector_if.sv
// rtl/r0_writeback_collector_if.sv - result-in / r0-register-out bundle for the writeback collector
interface r0_writeback_collector_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 en;
  logic [1:0]           state;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [WIDTH-1:0]     reg1;
  logic [WIDTH-1:0]     reg2;
  logic                 busy;
  logic                 ready;
  logic [CNT_WIDTH-1:0] wr_count;

  modport master (
    output en, state, in1, in2,
    input  reg1, reg2, busy, ready, wr_count
  );

  modport slave (
    input  en, state, in1, in2,
    output reg1, reg2, busy, ready, wr_count
  );
endinterface

// File: rtl/r0_writeback_collector.sv
// rtl/r0_writeback_collector.sv - writes one or two datapath results back into the r0 register pair
module r0_writeback_collector #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  r0_writeback_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE1 = 2'd1,
    WRITE2 = 2'd2,
    DONE   = 2'd3
  } fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [1:0]           hold_mode;
  logic [WIDTH-1:0]     hold1, hold2;
  logic [WIDTH-1:0]     reg1_q, reg2_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 busy_q, ready_q;
  logic                 accept;

  assign accept = (fsm_q == IDLE) && bus.en;

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.en) begin
          unique case (bus.state)
            2'd0:    fsm_d = DONE;
            2'd2:    fsm_d = WRITE2;
            default: fsm_d = WRITE1;
          endcase
        end
      end
      WRITE1:  fsm_d = (hold_mode == 2'd3) ? WRITE2 : DONE;
      WRITE2:  fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // busy/ready are registered from the next state so they line up with fsm_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= IDLE;
      hold_mode <= 2'd0;
      hold1     <= '0;
      hold2     <= '0;
      reg1_q    <= RESET_VALUE;
      reg2_q    <= RESET_VALUE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      busy_q  <= (fsm_d != IDLE);
      ready_q <= (fsm_d == DONE);
      if (accept) begin
        hold_mode <= bus.state;
        hold1     <= bus.in1;
        hold2     <= bus.in2;
      end
      if (fsm_q == WRITE1) begin
        reg1_q <= hold1;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
      end
      if (fsm_q == WRITE2) begin
        reg2_q <= hold2;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.reg1     = reg1_q;
  assign bus.reg2     = reg2_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_r0_writeback_collector.sv
// tb/tb_r0_writeback_collector.sv - directed scoreboard bench for r0_writeback_collector
module tb_r0_writeback_collector;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  typedef struct {
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] cnt;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_r1, m_r2, m_cnt;

  r0_writeback_collector_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();

  r0_writeback_collector #(.WIDTH(8), .RESET_VALUE(8'd0), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction: model updated and expectation queued at drive time,
  // popped and compared when ready is seen.
  task automatic txn(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                     input bit perturb);
    exp_t       e;
    exp_t       got;
    logic [7:0] prev_r2;
    bit         seen;
    prev_r2 = m_r2;
    if (mode == 2'd1 || mode == 2'd3) m_r1 = a;
    if (mode == 2'd2 || mode == 2'd3) m_r2 = b;
    e.lat = (mode == 2'd3) ? 2 : ((mode == 2'd0) ? 0 : 1);
    m_cnt = m_cnt + 8'(e.lat);
    e.r1  = m_r1;
    e.r2  = m_r2;
    e.cnt = m_cnt;
    sb.push_back(e);

    @(negedge clk);
    bus.en = 1'b1; bus.state = mode; bus.in1 = a; bus.in2 = b;
    @(posedge clk);
    @(negedge clk);
    if (perturb) begin
      bus.en = 1'b1; bus.state = ~mode; bus.in1 = ~a; bus.in2 = ~b;
    end else begin
      bus.en = 1'b0;
    end
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) bus.en = 1'b0;
      check("busy_in_txn", bus.busy, 1);
      if (mode == 2'd3 && n == 1) begin
        check("m3_reg1_first", bus.reg1, a);
        check("m3_reg2_not_yet", bus.reg2, prev_r2);
      end
      if (bus.ready) begin
        seen = 1'b1;
        got  = sb.pop_front();
        check("ready_latency", n, got.lat);
        check("reg1", bus.reg1, got.r1);
        check("reg2", bus.reg2, got.r2);
        check("wr_count", bus.wr_count, got.cnt);
        break;
      end
    end
    bus.en = 1'b0;
    if (!seen) begin
      check("ready_timeout", 0, 1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check("ready_single_pulse", bus.ready, 0);
    check("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    m_r1 = 8'd0; m_r2 = 8'd0; m_cnt = 8'd0;
    reset = 1'b1;
    bus.en = 1'b0; bus.state = 2'd0; bus.in1 = 8'd0; bus.in2 = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_reg1", bus.reg1, 0);
    check("rst_reg2", bus.reg2, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_cnt", bus.wr_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready_low", bus.ready, 0);

    txn(2'd1, 8'd1, 8'd2, 1'b0);
    txn(2'd3, 8'hA5, 8'h5A, 1'b0);
    txn(2'd3, 8'h3C, 8'hC3, 1'b1);
    txn(2'd0, 8'hFF, 8'hEE, 1'b0);
    txn(2'd2, 8'h77, 8'h11, 1'b0);

    // Counter wrap starting from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_r1 = 8'd0; m_r2 = 8'd0; m_cnt = 8'd0;
    for (int i = 0; i < 255; i++) txn(2'd1, 8'(i), 8'h00, 1'b0);
    check("cnt_preload", bus.wr_count, 255);
    txn(2'd1, 8'h9E, 8'h00, 1'b0);
    check("cnt_wrapped", bus.wr_count, 0);

    // Asynchronous reset in the middle of WRITE2
    @(negedge clk);
    bus.en = 1'b1; bus.state = 2'd3; bus.in1 = 8'h42; bus.in2 = 8'h24;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reg1", bus.reg1, 0);
    check("async_reg2", bus.reg2, 0);
    check("async_busy", bus.busy, 0);
    check("async_ready", bus.ready, 0);
    check("async_cnt", bus.wr_count, 0);
    @(negedge clk);
    reset = 1'b0;
    m_r1 = 8'd0; m_r2 = 8'd0; m_cnt = 8'd0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle_busy", bus.busy, 0);
      check("post_rst_idle_ready", bus.ready, 0);
      check("post_rst_reg2", bus.reg2, 0);
    end
    txn(2'd3, 8'h12, 8'h34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/r0_writeback_collector.md
Name: r0_writeback_collector

Overview:
- Return-path counterpart of the r0 multiplexer. It collects up to two 8-bit results (in1, in2) from the datapath and writes them back into the two r0 holding registers (reg1, reg2).
- Mode comes from the same 2-bit state code the multiplexer uses to fan r0 out.
- Operation is a sequenced, single-transaction block: accept on en, write one or two registers on successive cycles, then pulse ready.
- It sits between the ALU/result bus and the r0 register pair.

Parameters:
- WIDTH, 8, data width of in1/in2/reg1/reg2.
- RESET_VALUE, 0, value loaded into reg1/reg2 on reset.
- CNT_WIDTH, 8, width of the completed-write counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  start request; sampled only in IDLE.
- state  input  2  write-back mode: 0 none, 1 reg1 only, 2 reg2 only, 3 reg1 then reg2.
- in1  input  WIDTH  result destined for reg1.
- in2  input  WIDTH  result destined for reg2.
- reg1  output  WIDTH  r0 holding register 1.
- reg2  output  WIDTH  r0 holding register 2.
- busy  output  1  high while a transaction is in progress (FSM not IDLE).
- ready  output  1  one-cycle completion pulse.
- wr_count  output  CNT_WIDTH  number of register writes performed; wraps.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port reset.
- Reset (asynchronous, any time including mid-transaction):
  - FSM goes to IDLE.
  - reg1 = reg2 = RESET_VALUE; busy = 0; ready = 0; wr_count = 0.
  - Hold registers cleared. No partial write survives.
- FSM states: IDLE, WRITE1, WRITE2, DONE. All outputs are registered; busy = (state != IDLE).
- IDLE:
  - If en = 1 at an edge, latch state, in1 and in2 into hold registers.
  - Next state by mode: 0 goes to DONE; 1 or 3 go to WRITE1; 2 goes to WRITE2.
  - en = 0 keeps the FSM in IDLE.
- WRITE1: at the edge leaving this state, reg1 <= hold1 and wr_count increments. Next state is WRITE2 if mode = 3, else DONE.
- WRITE2: at the edge leaving this state, reg2 <= hold2 and wr_count increments. Next state is DONE.
- DONE: ready = 1 for exactly this one cycle. Next state is IDLE unconditionally.
- en behaviour:
  - en is ignored in WRITE1, WRITE2 and DONE. It is neither queued nor counted.
  - A request held high continuously is re-accepted on the first IDLE edge, so the minimum spacing between ready pulses is (cycles per transaction + 1).
- Latency, counted in edges after the accepting edge A:
  - Mode 0: ready high in the cycle after A; no writes.
  - Mode 1: reg1 updates at A+1; ready in the cycle after A+1.
  - Mode 2: reg2 updates at A+1; ready in the cycle after A+1.
  - Mode 3: reg1 updates at A+1, reg2 at A+2; ready in the cycle after A+2.
- in1, in2 and state are sampled only at the accepting edge. Changes during busy have no effect on the transaction in progress.
- Registers not selected by the mode keep their value.
- wr_count wraps from 2^CNT_WIDTH-1 to 0 with no flag. Mode 3 adds 2, modes 1 and 2 add 1, mode 0 adds 0.
- ready and busy are never both low while the FSM is in WRITE1 or WRITE2. ready is never high in IDLE.

Test Plan:
- Reset release, then en=1, state=1, in1=8'd1, in2=8'd2 -> reg1=1 one edge after accept, reg2 stays 0, single ready pulse, wr_count=1, busy high for 2 cycles.
- state=3, in1=8'hA5, in2=8'h5A -> reg1=A5 at A+1, reg2=5A at A+2, ready in the cycle after A+2 only, wr_count +2.
- state=3 accepted, then in1/in2/state changed and en pulsed during WRITE1 -> original values written, no second transaction, exactly one ready.
- state=0 with en=1 -> ready in the cycle after accept, reg1/reg2 unchanged, wr_count unchanged.
- Preload wr_count to 255 via repeated mode-1 writes (255 transactions), then one more mode-1 write -> wr_count=0, reg1 updated, ready pulse.
- Mode 3 started, reset asserted asynchronously mid-WRITE2 (between edges) -> immediately reg1=reg2=0, busy=0, ready=0, wr_count=0. After release, FSM idle until next en.
